// File: rtl/rtc_time_pkg.sv
// Shared types and limits for the RTC BCD time read path.
package rtc_time_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BIN_W  = 7;
   localparam int unsigned SEG_W  = 6;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned HORA_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      SEG,
      MIN,
      HORA,
      FIN
   } state_e;

   localparam logic [BIN_W-1:0]  MAX_SEG      = 7'd59;
   localparam logic [BIN_W-1:0]  MAX_MIN      = 7'd59;
   localparam logic [BIN_W-1:0]  MAX_HORA     = 7'd23;
   localparam logic [BIN_W-1:0]  MAX_HORA_12  = 7'd12;
   localparam logic [BYTE_W-1:0] BCD_INVALIDO = 8'hFF;

   // 12 AM -> 0, 12 PM -> 12, other PM hours shifted by 12.
   function automatic logic [HORA_W-1:0] hour12_to_24(input logic [HORA_W-1:0] h12,
                                                      input logic             pm);
      logic [HORA_W-1:0] base;
      base = (h12 == 5'd12) ? 5'd0 : h12;
      return pm ? HORA_W'(base + 5'd12) : base;
   endfunction

endpackage

// File: rtl/bcd_byte_to_bin.sv
// Combinational BCD byte to binary conversion with nibble, range and sentinel checks.
module bcd_byte_to_bin
   import rtc_time_pkg::*;
(
   input  logic [BYTE_W-1:0] byte_i,
   input  logic [BIN_W-1:0]  max_i,
   output logic [BIN_W-1:0]  bin_o,
   output logic              ok_o
);

   logic [3:0] hi;
   logic [3:0] lo;

   assign hi    = byte_i[7:4];
   assign lo    = byte_i[3:0];
   assign bin_o = BIN_W'(BIN_W'(hi) * 7'd10 + BIN_W'(lo));
   assign ok_o  = (hi <= 4'd9) && (lo <= 4'd9) && (bin_o <= max_i)
                  && (byte_i != BCD_INVALIDO);

endmodule

// File: rtl/bcd_time_decoder.sv
// Collects seconds/minutes/hours BCD bytes from the RTC and publishes a checked binary time.
// Optional 12-h hours format enabled by the FORMATO_12H_EN macro.
module bcd_time_decoder
   import rtc_time_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 8
)
(
   input  logic              clk,
   input  logic              reset,
`ifdef FORMATO_12H_EN
   input  logic              formato_12h,
`endif
   input  logic              start,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              data_valid,
   output logic              busy,
   output logic [SEG_W-1:0]  segundos,
   output logic [MIN_W-1:0]  minutos,
   output logic [HORA_W-1:0] horas,
   output logic              done,
   output logic              error
);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [SEG_W-1:0]    seg_sh_q, seg_sh_d;
   logic [MIN_W-1:0]    min_sh_q, min_sh_d;
   logic [HORA_W-1:0]   hora_sh_q, hora_sh_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic [MIN_W-1:0]    min_q, min_d;
   logic [HORA_W-1:0]   hora_q, hora_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                busy_q, busy_d;
`ifdef FORMATO_12H_EN
   logic                fmt12_q, fmt12_d;
`endif

   logic [BYTE_W-1:0]   dec_byte;
   logic [BIN_W-1:0]    dec_max;
   logic [BIN_W-1:0]    dec_bin;
   logic                dec_ok;
   logic [HORA_W-1:0]   hora_bin;
   logic                hora_ok;

   bcd_byte_to_bin u_dec (
      .byte_i (dec_byte),
      .max_i  (dec_max),
      .bin_o  (dec_bin),
      .ok_o   (dec_ok)
   );

   // Single shared decoder: limit (and hours byte masking) follow the current field.
   always_comb begin
      dec_byte = data_in;
      dec_max  = MAX_SEG;
      if (state_q == MIN) begin
         dec_max = MAX_MIN;
      end else if (state_q == HORA) begin
         dec_max = MAX_HORA;
`ifdef FORMATO_12H_EN
         if (fmt12_q) begin
            dec_byte = {3'b000, data_in[4:0]};
            dec_max  = MAX_HORA_12;
         end
`endif
      end
   end

   always_comb begin
      hora_bin = HORA_W'(dec_bin);
      hora_ok  = dec_ok;
`ifdef FORMATO_12H_EN
      if (fmt12_q) begin
         hora_ok  = dec_ok && (dec_bin != '0);
         hora_bin = hour12_to_24(HORA_W'(dec_bin), data_in[5]);
      end
`endif
   end

   // Next-state and output logic; visible time changes only when entering FIN.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      seg_sh_d  = seg_sh_q;
      min_sh_d  = min_sh_q;
      hora_sh_d = hora_sh_q;
      seg_d     = seg_q;
      min_d     = min_q;
      hora_d    = hora_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
`ifdef FORMATO_12H_EN
      fmt12_d   = fmt12_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEG;
               cnt_d   = '0;
               err_d   = 1'b0;
`ifdef FORMATO_12H_EN
               fmt12_d = formato_12h;
`endif
            end
         end
         SEG, MIN, HORA: begin
            if (data_valid) begin
               cnt_d = '0;
               case (state_q)
                  SEG: begin
                     seg_sh_d = SEG_W'(dec_bin);
                     err_d    = err_q | ~dec_ok;
                     state_d  = MIN;
                  end
                  MIN: begin
                     min_sh_d = MIN_W'(dec_bin);
                     err_d    = err_q | ~dec_ok;
                     state_d  = HORA;
                  end
                  default: begin
                     hora_sh_d = hora_bin;
                     err_d     = err_q | ~hora_ok;
                     state_d   = FIN;
                     if (!err_d) begin
                        seg_d  = seg_sh_q;
                        min_d  = min_sh_q;
                        hora_d = hora_bin;
                        done_d = 1'b1;
                     end else begin
                        error_d = 1'b1;
                     end
                  end
               endcase
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = FIN;
               err_d   = 1'b1;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         seg_sh_q  <= '0;
         min_sh_q  <= '0;
         hora_sh_q <= '0;
         seg_q     <= '0;
         min_q     <= '0;
         hora_q    <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef FORMATO_12H_EN
         fmt12_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         seg_sh_q  <= seg_sh_d;
         min_sh_q  <= min_sh_d;
         hora_sh_q <= hora_sh_d;
         seg_q     <= seg_d;
         min_q     <= min_d;
         hora_q    <= hora_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
`ifdef FORMATO_12H_EN
         fmt12_q   <= fmt12_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign segundos = seg_q;
   assign minutos  = min_q;
   assign horas    = hora_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_bcd_time_decoder.sv
// Directed and randomized frames for bcd_time_decoder checked against an arithmetic time model.
module tb_bcd_time_decoder;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] data_in;
   logic       dv;
   logic       busy;
   logic [5:0] segundos;
   logic [5:0] minutos;
   logic [4:0] horas;
   logic       done;
   logic       error;
`ifdef FORMATO_12H_EN
   logic       formato_12h;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_s = 0, exp_m = 0, exp_h = 0;

   bcd_time_decoder #(.TIMEOUT(TO), .CW(8)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef FORMATO_12H_EN
      .formato_12h(formato_12h),
`endif
      .start      (start),
      .data_in    (data_in),
      .data_valid (dv),
      .busy       (busy),
      .segundos   (segundos),
      .minutos    (minutos),
      .horas      (horas),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_time(input string tag);
      check({tag, ".seg"}, 32'(segundos), 32'(exp_s));
      check({tag, ".min"}, 32'(minutos),  32'(exp_m));
      check({tag, ".hora"}, 32'(horas),   32'(exp_h));
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic bit bcd_ok(input logic [7:0] b, input int lim, output int v);
      int hi, lo;
      hi = int'(b) / 16;
      lo = int'(b) % 16;
      v  = hi * 10 + lo;
      return (hi < 10) && (lo < 10) && (v <= lim);
   endfunction

   function automatic void model(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                                 input bit f12, output bit ok,
                                 output int vs, output int vm, output int vh);
      int h12;
      ok = bcd_ok(s, 59, vs);
      ok = bcd_ok(m, 59, vm) && ok;
      if (f12) begin
         ok = bcd_ok(h & 8'h1F, 12, h12) && (h12 != 0) && ok;
         vh = (h12 % 12) + (h[5] ? 12 : 0);
      end else begin
         ok = bcd_ok(h, 23, vh) && ok;
      end
   endfunction

   task automatic run_frame(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input bit f12, input int gap, input bit fin_noise);
      bit ok;
      int vs, vm, vh;
      logic [7:0] b [3];
      model(s, m, h, f12, ok, vs, vm, vh);
      b[0] = s; b[1] = m; b[2] = h;
`ifdef FORMATO_12H_EN
      formato_12h = f12;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         repeat (gap) tick();
         data_in = b[i];
         dv = 1'b1;
         tick();
         dv = 1'b0;
      end
      if (ok) begin
         exp_s = vs; exp_m = vm; exp_h = vh;
      end
      check("fin.done",  32'(done),  32'(ok));
      check("fin.error", 32'(error), 32'(!ok));
      check_time("fin");
      if (fin_noise) begin
         start   = 1'b1;
         dv      = 1'b1;
         data_in = 8'h11;
      end
      tick();
      start = 1'b0;
      dv    = 1'b0;
      check("post.busy",  32'(busy),  32'd0);
      check("post.done",  32'(done),  32'd0);
      check("post.error", 32'(error), 32'd0);
      check_time("post");
   endtask

   function automatic logic [7:0] rand_field(input int lim);
      if ($urandom_range(0, 9) < 8) return to_bcd(int'($urandom_range(0, lim)));
      return 8'($urandom);
   endfunction

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      dv      = 1'b0;
      data_in = 8'h00;
`ifdef FORMATO_12H_EN
      formato_12h = 1'b0;
`endif
      tick();
      tick();
      check("rst.busy",  32'(busy),  32'd0);
      check("rst.done",  32'(done),  32'd0);
      check("rst.error", 32'(error), 32'd0);
      check_time("rst");
      reset = 1'b0;
      tick();

      // Directed frames including range boundaries and the sentinel.
      run_frame(8'h45, 8'h30, 8'h23, 1'b0, 1, 1'b0);
      run_frame(8'h56, 8'h34, 8'h12, 1'b0, 0, 1'b0);
      run_frame(8'h00, 8'h00, 8'h00, 1'b0, 1, 1'b0);
      run_frame(8'h59, 8'h3A, 8'h10, 1'b0, 1, 1'b0);
      run_frame(8'h59, 8'h30, 8'h24, 1'b0, 2, 1'b0);
      run_frame(8'h59, 8'h30, 8'hFF, 1'b0, 0, 1'b0);
      run_frame(8'h60, 8'h00, 8'h01, 1'b0, 3, 1'b0);
      run_frame(8'h59, 8'h59, 8'h23, 1'b0, 3, 1'b1);
      run_frame(8'h07, 8'h60, 8'h05, 1'b0, 1, 1'b1);

      // data_valid while idle must be ignored.
      data_in = 8'h22;
      dv = 1'b1;
      tick();
      tick();
      dv = 1'b0;
      check("idle_dv.busy", 32'(busy), 32'd0);
      check("idle_dv.done", 32'(done), 32'd0);
      check_time("idle_dv");

      for (int i = 0; i < 30; i++) begin
         run_frame(rand_field(59), rand_field(59), rand_field(23), 1'b0,
                   int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)));
      end

      // Stalled frame after the seconds byte; a restart attempt mid-frame is ignored.
      start = 1'b1;
      tick();
      start = 1'b0;
      data_in = 8'h12;
      dv = 1'b1;
      tick();
      dv = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("to.busy_wait", 32'(busy),  32'd1);
      check("to.no_err",    32'(error), 32'd0);
      tick();
      check("to.error", 32'(error), 32'd1);
      check("to.done",  32'(done),  32'd0);
      check_time("to");
      tick();
      check("to.idle",  32'(busy),  32'd0);
      check("to.err_1", 32'(error), 32'd0);

      // Reset in the middle of a frame discards it and clears the outputs.
      run_frame(8'h56, 8'h34, 8'h12, 1'b0, 0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      data_in = 8'h33;
      dv = 1'b1;
      tick();
      dv = 1'b0;
      reset = 1'b1;
      #1;
      exp_s = 0; exp_m = 0; exp_h = 0;
      check("mid_rst.busy", 32'(busy), 32'd0);
      check_time("mid_rst");
      tick();
      reset = 1'b0;
      tick();
      run_frame(8'h01, 8'h02, 8'h03, 1'b0, 1, 1'b0);

`ifdef FORMATO_12H_EN
      run_frame(8'h10, 8'h20, 8'h12, 1'b1, 1, 1'b0);
      run_frame(8'h10, 8'h20, 8'h32, 1'b1, 1, 1'b0);
      run_frame(8'h10, 8'h20, 8'h31, 1'b1, 1, 1'b0);
      run_frame(8'h10, 8'h20, 8'h13, 1'b1, 1, 1'b0);
      run_frame(8'h10, 8'h20, 8'h20, 1'b1, 1, 1'b0);
      run_frame(8'h10, 8'h20, 8'hC7, 1'b1, 1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         run_frame(rand_field(59), rand_field(59), 8'($urandom), 1'($urandom_range(0, 1)),
                   1, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
